// File: rtl/wait_thread_scheduler.sv
// wait_thread_scheduler
// Shared wait(N) counter bank for synthesized thread FSMs. Each thread parks
// for a programmed number of cycles, then competes for one shared resume
// slot through a round-robin arbiter (at most one grant per cycle).

module wait_thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int WAIT_W      = 8,
  parameter int ID_W        = $clog2(NUM_THREADS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_THREADS-1:0]        req_valid,
  input  logic [NUM_THREADS*WAIT_W-1:0] req_count,
  output logic [NUM_THREADS-1:0]        req_ready,
  input  logic                          grant_en,
  output logic [NUM_THREADS-1:0]        grant,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic [NUM_THREADS-1:0]        waiting
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_READY   = 2'd2
  } thread_state_t;

  // Width-matched constants for the pointer and counter arithmetic.
  localparam logic [ID_W:0]     NUM_THREADS_W = (ID_W+1)'(NUM_THREADS);
  localparam logic [ID_W-1:0]   LAST_ID       = ID_W'(NUM_THREADS-1);
  localparam logic [ID_W-1:0]   ID_ONE        = ID_W'(1);
  localparam logic [WAIT_W-1:0] CNT_ONE       = WAIT_W'(1);

  // Per-thread status decoded from registered state only.
  logic [NUM_THREADS-1:0] idle_vec;
  logic [NUM_THREADS-1:0] wait_vec;
  logic [NUM_THREADS-1:0] ready_vec;

  // Arbiter results and round-robin pointer.
  logic [NUM_THREADS-1:0] grant_vec;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_found;
  logic [ID_W-1:0]        rr_reg;
  logic [ID_W-1:0]        rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      thread_state_t     state_reg;
      thread_state_t     state_next;
      logic [WAIT_W-1:0] cnt_reg;
      logic [WAIT_W-1:0] cnt_next;
      logic [WAIT_W-1:0] req_k;
      logic              accept;

      assign req_k  = req_count[gi*WAIT_W +: WAIT_W];
      // Only an IDLE thread takes a request; busy requests are dropped.
      assign accept = req_valid[gi] && (state_reg == ST_IDLE);

      // Thread FSM next-state: park, count down unconditionally, wait for grant.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          ST_IDLE: begin
            if (accept) begin
              if (req_k == '0) begin
                state_next = ST_READY;
                cnt_next   = '0;
              end else begin
                state_next = ST_WAITING;
                cnt_next   = req_k;
              end
            end
          end
          ST_WAITING: begin
            if (cnt_reg == CNT_ONE) begin
              state_next = ST_READY;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          ST_READY: begin
            if (grant_vec[gi]) begin
              state_next = ST_IDLE;
            end
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      // Thread state and counter registers; reset discards any pending wait.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign idle_vec[gi]  = (state_reg == ST_IDLE);
      assign wait_vec[gi]  = (state_reg == ST_WAITING);
      assign ready_vec[gi] = (state_reg == ST_READY);
    end
  endgenerate

  // Round-robin arbiter: first READY thread scanning from rr, wrapping.
  always_comb begin
    logic [ID_W:0]   idx_wide;
    logic [ID_W-1:0] idx;
    grant_vec   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx_wide    = '0;
    idx         = '0;
    if (grant_en && !reset) begin
      for (int off = 0; off < NUM_THREADS; off++) begin
        idx_wide = {1'b0, rr_reg} + (ID_W+1)'(off);
        if (idx_wide >= NUM_THREADS_W) begin
          idx_wide = idx_wide - NUM_THREADS_W;
        end
        idx = idx_wide[ID_W-1:0];
        if (!grant_found && ready_vec[idx]) begin
          grant_found    = 1'b1;
          grant_vec[idx] = 1'b1;
          grant_idx      = idx;
        end
      end
    end
  end

  // Pointer advances past the winner; unchanged when nothing is granted.
  always_comb begin
    rr_next = rr_reg;
    if (grant_found) begin
      rr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_ONE;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_reg <= '0;
    end else begin
      rr_reg <= rr_next;
    end
  end

  // Outputs are forced to their reset values while reset is held.
  assign grant       = grant_vec;
  assign grant_valid = grant_found;
  assign grant_id    = grant_idx;
  assign req_ready   = idle_vec | {NUM_THREADS{reset}};
  assign waiting     = wait_vec & ~{NUM_THREADS{reset}};

endmodule

// File: doc/wait_thread_scheduler.md
Name: wait_thread_scheduler

Overview:
- Shared wait-counter scheduler for synthesized SystemC threads.
- Each requester thread parks itself for a programmed number of cycles, the equivalent of wait(N).
- When the count expires, the thread competes with other expired threads for a single shared resume/datapath slot.
- A round-robin arbiter grants at most one thread per cycle, so one resource is shared among NUM_THREADS thread FSMs without per-thread duplication of the downstream datapath.

Parameters:
- NUM_THREADS, 4: number of requester threads; must be ≥2.
- WAIT_W, 8: width of each requested wait count; maximum wait is 2^WAIT_W-1 cycles.
- ID_W, $clog2(NUM_THREADS): width of grant_id.

Ports:
- clk  input  1: single clock; all state updates on the posedge.
- reset  input  1: synchronous, active-high reset, sampled on posedge clk.
- req_valid  input  NUM_THREADS: bit i set = thread i requests a wait.
- req_count  input  NUM_THREADS*WAIT_W: packed counts; thread i uses bits [i*WAIT_W +: WAIT_W].
- req_ready  output  NUM_THREADS: bit i = thread i is IDLE and can accept a request.
- grant_en  input  1: shared resource available this cycle; when low, no grant is issued.
- grant  output  NUM_THREADS: one-hot resume grant; all zero when none.
- grant_valid  output  1: OR of grant.
- grant_id  output  ID_W: index of the granted thread; 0 when grant_valid=0.
- waiting  output  NUM_THREADS: bit i = thread i is in WAITING state.

Behaviour:
- Per-thread state is IDLE, WAITING or READY, plus a WAIT_W-bit counter cnt[i]. Round-robin pointer rr has width ID_W.
- Reset (synchronous, any time, including mid-wait or while READY): every thread goes to IDLE, cnt=0, rr=0. Pending waits are discarded.
- Output values during and after reset:
  - req_ready = all ones.
  - grant = 0, grant_valid = 0, grant_id = 0.
  - waiting = 0.
- Handshake: request i is accepted at the edge where req_valid[i] && req_ready[i]. req_ready[i] = (state[i]==IDLE) and is decoded from registers only (no combinational path from req_valid). req_valid while not ready is ignored; no queuing.
- On accept with count k:
  - k=0: thread goes directly to READY at that edge.
  - k≥1: thread goes to WAITING with cnt=k.
- WAITING: cnt decrements by 1 every edge. At the edge where cnt==1, the thread moves to READY and cnt becomes 0.
  - Net effect: a request accepted at edge t with k≥1 is first READY in the cycle after edge t+k, i.e. it is eligible for grant exactly k cycles after acceptance.
- Decrement is unconditional: grant_en and arbitration do not stall counting.
- Arbitration is combinational from registered state.
  - If grant_en=1 and any thread is READY: grant the first READY index found scanning rr, rr+1, …, wrapping modulo NUM_THREADS.
  - At that edge the granted thread goes to IDLE and rr becomes (granted index + 1) mod NUM_THREADS. The wrap applies when NUM_THREADS is not a power of two.
  - If there is no grant, rr is unchanged.
- READY threads hold READY indefinitely while grant_en=0 or while they lose arbitration. Starvation bound: at most NUM_THREADS-1 grant cycles.
- A granted thread sees req_ready=1 in the following cycle. There is no same-cycle re-arm: a request presented during the grant cycle is not accepted.
- Multiple threads may accept requests on the same edge. Acceptance on thread i is independent of grant activity on thread j.
- All outputs are derived from registered state; there are no latches. Every combinational signal has a default assignment.
- Counter arithmetic is unsigned WAIT_W-bit. cnt never underflows because decrement happens only in WAITING with cnt≥1.

Test Plan:
1. Reset, then a single wait. Reset for 2 cycles, then thread 1 requests count=3 at edge t.
   - waiting[1]=1 for edges t..t+2.
   - grant=4'b0010 and grant_id=1 in the cycle after edge t+3.
   - req_ready[1]=1 in the next cycle.
2. Zero count. Thread 2 requests count=0 at edge t.
   - grant=4'b0100 in the cycle immediately after t; waiting[2] is never set.
3. Round-robin fairness. Threads 0–3 all request count=2 on the same edge.
   - Grants appear on 4 consecutive cycles in order 0,1,2,3.
   - A re-request of thread 0 with count=0 while rr=1 is granted only after thread 3.
4. grant_en hold-off. Threads 0 and 3 become READY while grant_en=0 for 5 cycles.
   - No grant during those cycles.
   - After grant_en=1 with rr=2: thread 3 is granted first, then thread 0. Counting of other WAITING threads continues during the hold-off.
5. Mid-operation reset. Thread 0 is WAITING with cnt=200 and thread 1 is READY; assert reset for 1 cycle.
   - Next cycle: waiting=0, grant_valid=0, req_ready=4'b1111, rr=0.
   - No stale grant follows.
6. Max count and busy retry. Thread 3 requests count=255 (WAIT_W=8).
   - Granted exactly 255 cycles after acceptance.
   - req_valid[3] held high while WAITING causes no re-acceptance: cnt is not reloaded.
